masked_burst_ram: RTL and testbench

MASKED_BURST_RAM -- requirements
Module: masked_burst_ram

---
 rtl/masked_burst_ram.sv | 180 ++++++++++++++++++
 tb/tb_masked_burst_ram.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_burst_ram.sv
// Burst RAM with post-reset calibration delay, fixed read latency and bursts that wrap inside a
// BurstDataCount-aligned block. Define MASKED_BURST_RAM_DATA_MASK_EN to honour data_mask on writes.
module masked_burst_ram #(
   parameter string DataFilePath          = "",
   parameter int    AddressBitWidth       = 4,
   parameter int    DataBitWidth          = 64,
   parameter int    BurstDataCount        = 4,
   parameter int    CyclesBeforeDataValid = 6,
   parameter int    CyclesBeforeInitiated = 10
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cmd,
   input  logic                          cmd_en,
   input  logic [AddressBitWidth-1:0]    addr,
   input  logic [DataBitWidth-1:0]       wr_data,
   input  logic [DataBitWidth/8-1:0]     data_mask,
   output logic [DataBitWidth-1:0]       rd_data,
   output logic                          rd_data_valid,
   output logic                          init_calib,
   output logic                          busy
);

   localparam int NB    = DataBitWidth / 8;
   localparam int DEPTH = 1 << AddressBitWidth;
   localparam int BW    = (BurstDataCount > 1) ? $clog2(BurstDataCount) : 1;
   localparam int WW    = (CyclesBeforeDataValid > 1) ? $clog2(CyclesBeforeDataValid) : 1;
   localparam int IW    = (CyclesBeforeInitiated > 1) ? $clog2(CyclesBeforeInitiated) : 1;

   localparam logic [AddressBitWidth-1:0] OFF_MASK = AddressBitWidth'(BurstDataCount - 1);
   localparam logic [BW-1:0]              LAST_BEAT = BW'(BurstDataCount - 1);

   localparam logic [2:0] ST_INIT        = 3'd0;
   localparam logic [2:0] ST_IDLE        = 3'd1;
   localparam logic [2:0] ST_READ_WAIT   = 3'd2;
   localparam logic [2:0] ST_READ_BURST  = 3'd3;
   localparam logic [2:0] ST_WRITE_BURST = 3'd4;

   logic [2:0]                 state_q, state_d;
   logic [AddressBitWidth-1:0] base_q, base_d;
   logic [BW-1:0]              beat_q, beat_d;
   logic [WW-1:0]              wait_q, wait_d;
   logic [IW-1:0]              init_q, init_d;
   logic                       rd_valid_q, rd_valid_d;
   logic [DataBitWidth-1:0]    rd_data_q;

   logic                       rd_en;
   logic                       wr_en;
   logic [AddressBitWidth-1:0] wr_addr;
   logic [AddressBitWidth-1:0] rd_addr;
   logic [NB-1:0]              byte_we;

   logic [DataBitWidth-1:0]    mem_q [DEPTH];

   // Keep the block bits of the start address and let only the low offset bits advance.
   function automatic logic [AddressBitWidth-1:0] wrap_addr(
      input logic [AddressBitWidth-1:0] base,
      input logic [BW-1:0]              beat
   );
      return (base & ~OFF_MASK) | ((base + AddressBitWidth'(beat)) & OFF_MASK);
   endfunction

   assign rd_addr = wrap_addr(base_q, beat_q);

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      beat_d     = beat_q;
      wait_d     = wait_q;
      init_d     = init_q;
      rd_valid_d = 1'b0;
      rd_en      = 1'b0;
      wr_en      = 1'b0;
      wr_addr    = addr;
      case (state_q)
         ST_INIT: begin
            if (init_q == '0) state_d = ST_IDLE;
            else              init_d  = init_q - IW'(1);
         end
         ST_IDLE: begin
            if (cmd_en) begin
               base_d = addr;
               if (cmd) begin
                  // Beat 0 of a write lands on the accepting edge itself.
                  wr_en   = 1'b1;
                  wr_addr = addr;
                  beat_d  = BW'(1);
                  if (BurstDataCount > 1) state_d = ST_WRITE_BURST;
               end else begin
                  beat_d = '0;
                  wait_d = WW'(CyclesBeforeDataValid - 2);
                  if (CyclesBeforeDataValid == 1) state_d = ST_READ_BURST;
                  else                            state_d = ST_READ_WAIT;
               end
            end
         end
         ST_READ_WAIT: begin
            if (wait_q == '0) state_d = ST_READ_BURST;
            else              wait_d  = wait_q - WW'(1);
         end
         ST_READ_BURST: begin
            rd_en      = 1'b1;
            rd_valid_d = 1'b1;
            if (beat_q == LAST_BEAT) begin
               state_d = ST_IDLE;
               beat_d  = '0;
            end else begin
               beat_d = beat_q + BW'(1);
            end
         end
         ST_WRITE_BURST: begin
            wr_en   = 1'b1;
            wr_addr = wrap_addr(base_q, beat_q);
            if (beat_q == LAST_BEAT) begin
               state_d = ST_IDLE;
               beat_d  = '0;
            end else begin
               beat_d = beat_q + BW'(1);
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_INIT;
         base_q     <= '0;
         beat_q     <= '0;
         wait_q     <= '0;
         init_q     <= IW'(CyclesBeforeInitiated - 1);
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         beat_q     <= beat_d;
         wait_q     <= wait_d;
         init_q     <= init_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Reset gates the write strobe so an aborted burst leaves memory untouched from that edge on.
   for (genvar gi = 0; gi < NB; gi++) begin : g_byte_we
`ifdef MASKED_BURST_RAM_DATA_MASK_EN
      assign byte_we[gi] = wr_en && rst_n && !data_mask[gi];
`else
      assign byte_we[gi] = wr_en && rst_n;
`endif
   end

`ifndef MASKED_BURST_RAM_DATA_MASK_EN
   logic unused_mask;
   assign unused_mask = ^data_mask;
`endif

   logic unused_path;
   assign unused_path = (DataFilePath == "");

   initial begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (byte_we[i]) mem_q[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)     rd_data_q <= '0;
      else if (rd_en) rd_data_q <= mem_q[rd_addr];
   end

   assign rd_data       = rd_data_q;
   assign rd_data_valid = rd_valid_q;
   assign init_calib    = (state_q != ST_INIT);
   assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_masked_burst_ram.sv
// Randomised bench for masked_burst_ram: a timeline model (edge numbers, array memory) predicts
// every output each cycle; literal checks pin calibration length, latency, wrap and masking.
`timescale 1ns/1ps
module tb_masked_burst_ram;

   localparam int AW = 4, DW = 64, B = 4, L = 6, C = 10, NB = 8, DEPTH = 16;
`ifdef MASKED_BURST_RAM_DATA_MASK_EN
   localparam bit MASK_EN = 1'b1;
`else
   localparam bit MASK_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd = 1'b0;
   logic          cmd_en = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [NB-1:0] data_mask = '0;
   logic [DW-1:0] rd_data;
   logic          rd_data_valid;
   logic          init_calib;
   logic          busy;

   masked_burst_ram #(
      .DataFilePath(""), .AddressBitWidth(AW), .DataBitWidth(DW), .BurstDataCount(B),
      .CyclesBeforeDataValid(L), .CyclesBeforeInitiated(C)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_en(cmd_en), .addr(addr), .wr_data(wr_data),
      .data_mask(data_mask), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
      .init_calib(init_calib), .busy(busy)
   );

   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   logic [DW-1:0] model_mem [DEPTH];
   logic [DW-1:0] exp_rd [int];
   logic [DW-1:0] last_rd = '0;
   logic [DW-1:0] wdat [B];
   logic [NB-1:0] wmsk [B];
   int            last_rst = -1000;
   int            first_rst = -1;
   int            next_accept = 0;
   int            last_acc = 0;
   int            errors = 0;
   int            checks = 0;
   int            cap_edge[$];
   logic [DW-1:0] cap_data[$];

   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, got, exp);
      end
   endtask

   function automatic int beat_addr(input int a, input int k);
      return (a / B) * B + ((a % B) + k) % B;
   endfunction

   function automatic void model_write(input int ad, input logic [DW-1:0] d, input logic [NB-1:0] m);
      for (int i = 0; i < NB; i++)
         if (!MASK_EN || !m[i]) model_mem[ad][i*8 +: 8] = d[i*8 +: 8];
   endfunction

   // Per-cycle comparison against the timeline model.
   int   e;
   logic exp_v;
   always begin
      @(posedge clk);
      #1;
      if (rd_data_valid) begin
         cap_edge.push_back(edge_n);
         cap_data.push_back(rd_data);
      end
      if (first_rst >= 0 && edge_n >= first_rst) begin
         e = edge_n;
         if (e == last_rst) begin
            check("rst_valid", {63'b0, rd_data_valid}, '0);
            check("rst_rd_data", rd_data, '0);
            check("rst_busy", {63'b0, busy}, 64'd1);
            check("rst_init_calib", {63'b0, init_calib}, '0);
            last_rd = '0;
         end else begin
            exp_v = exp_rd.exists(e);
            check("rd_valid", {63'b0, rd_data_valid}, {63'b0, exp_v});
            if (exp_v) begin
               check("rd_data", rd_data, exp_rd[e]);
               last_rd = exp_rd[e];
               exp_rd.delete(e);
            end else begin
               check("rd_hold", rd_data, last_rd);
            end
            check("busy", {63'b0, busy}, {63'b0, (e + 1 < next_accept)});
            check("init_calib", {63'b0, init_calib}, {63'b0, (e >= last_rst + C)});
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (edge_n + 1 < next_accept && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle_bound", n >= 300, '0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst_n = 1'b0;
         cmd_en = 1'b0;
         last_rst = edge_n + 1;
         if (first_rst < 0) first_rst = edge_n + 1;
         exp_rd.delete();
         next_accept = last_rst + C + 1;
      end
      @(negedge clk);
      rst_n = 1'b1;
      next_accept = last_rst + C + 1;
   endtask

   // Writes wdat/wmsk as one burst; abort_k asserts reset at that beat, pulse_k raises a stray cmd_en.
   task automatic do_write(input int a, input int abort_k, input int pulse_k);
      int n;
      @(negedge clk);
      cmd_en = 1'b0;
      wait_idle();
      n = edge_n + 1;
      next_accept = n + B;
      for (int k = 0; k < B; k++) begin
         if (k > 0) @(negedge clk);
         wr_data = wdat[k];
         data_mask = wmsk[k];
         if (k == abort_k) begin
            rst_n = 1'b0;
            cmd_en = 1'b0;
            last_rst = edge_n + 1;
            exp_rd.delete();
            next_accept = last_rst + C + 1;
            return;
         end
         cmd_en = (k == 0) || (k == pulse_k);
         cmd = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         addr = (k == 0) ? AW'(a) : AW'($urandom);
         model_write(beat_addr(a, k), wdat[k], wmsk[k]);
      end
   endtask

   task automatic do_read(input int a, input bit pulse);
      int n;
      @(negedge clk);
      cmd_en = 1'b0;
      wait_idle();
      n = edge_n + 1;
      last_acc = n;
      cmd_en = 1'b1;
      cmd = 1'b0;
      addr = AW'(a);
      for (int k = 0; k < B; k++) exp_rd[n + L + k] = model_mem[beat_addr(a, k)];
      next_accept = n + L + B;
      @(negedge clk);
      cmd_en = 1'b0;
      if (pulse) begin
         @(negedge clk);
         cmd_en = 1'b1;
         cmd = 1'($urandom_range(0, 1));
         addr = AW'($urandom);
         wr_data = {$urandom, $urandom};
         data_mask = '0;
         @(negedge clk);
         cmd_en = 1'b0;
      end
   endtask

   task automatic lit_read(input string nm, input int a, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                           input logic [DW-1:0] e2, input logic [DW-1:0] e3);
      int t = 0;
      cap_edge.delete();
      cap_data.delete();
      do_read(a, 1'b0);
      while (cap_data.size() < B && t < 40) begin
         @(negedge clk);
         t++;
      end
      check({nm, "_beats"}, cap_data.size(), B);
      if (cap_data.size() >= B) begin
         check({nm, "_first_edge"}, cap_edge[0], last_acc + 6);
         check({nm, "_last_edge"}, cap_edge[3], last_acc + 9);
         check({nm, "_b0"}, cap_data[0], e0);
         check({nm, "_b1"}, cap_data[1], e1);
         check({nm, "_b2"}, cap_data[2], e2);
         check({nm, "_b3"}, cap_data[3], e3);
      end
   endtask

   task automatic fill_wdat(input bit rnd_mask);
      for (int k = 0; k < B; k++) begin
         wdat[k] = {$urandom, $urandom};
         wmsk[k] = rnd_mask ? NB'($urandom) : '0;
      end
   endtask

   initial begin
      int cnt;
      logic [DW-1:0] m37;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

      do_reset(3);
      cnt = 0;
      while (!init_calib && cnt < 50) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      check("calib_cycles", cnt, C);

      for (int blk = 0; blk < DEPTH; blk += B) begin
         fill_wdat(1'b0);
         do_write(blk, -1, -1);
      end

      wdat[0] = 64'h11; wdat[1] = 64'h22; wdat[2] = 64'h33; wdat[3] = 64'h44;
      for (int k = 0; k < B; k++) wmsk[k] = '0;
      do_write(4, -1, -1);
      lit_read("rd_addr4", 4, 64'h11, 64'h22, 64'h33, 64'h44);
      lit_read("rd_addr6_wrap", 6, 64'h33, 64'h44, 64'h11, 64'h22);

      for (int k = 0; k < B; k++) begin wdat[k] = '0; wmsk[k] = '0; end
      do_write(0, -1, -1);
      for (int k = 0; k < B; k++) begin wdat[k] = '1; wmsk[k] = 8'h0F; end
      do_write(0, -1, -1);
      m37 = MASK_EN ? 64'hFFFF_FFFF_0000_0000 : 64'hFFFF_FFFF_FFFF_FFFF;
      lit_read("masked_write", 0, m37, m37, m37, m37);

      do_read(8, 1'b1);
      fill_wdat(1'b0);
      do_write(12, -1, 2);
      do_read(12, 1'b0);
      do_read(8, 1'b0);
      do_read(0, 1'b0);

      fill_wdat(1'b0);
      do_write(8, 2, -1);
      do_reset(2);
      do_read(8, 1'b0);
      do_read(4, 1'b0);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            fill_wdat(1'b1);
            do_write(int'($urandom_range(0, DEPTH - 1)), -1,
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, B - 1)) : -1);
         end else begin
            do_read(int'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 1)));
         end
      end

      @(negedge clk);
      cmd_en = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      check("pending_reads", exp_rd.num(), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
